// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused LSB-first over WIDTH clocks.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds port sub).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] areg, breg;
    logic [WIDTH-2:0] rreg;
    logic [WIDTH-1:0] rreg_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    assign fa_sum   = areg[0] ^ breg[0] ^ carry;
    assign fa_carry = (areg[0] & breg[0]) | (areg[0] & carry) | (breg[0] & carry);
    assign rreg_nxt = {fa_sum, rreg};
    assign last     = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            areg  <= '0;
            breg  <= '0;
            rreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            areg  <= a;
            breg  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == BUSY) begin
            rreg  <= rreg_nxt[WIDTH-1:1];
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            carry <= fa_carry;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= rreg_nxt;
                cout <= fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8, add-only build).
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;
    logic [W-1:0] exp_sum;
    logic         exp_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request; the reference result is plain (W+1)-bit arithmetic.
    task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
        logic [W:0] t;
        a     = aa;
        b     = bb;
        cin   = c;
        start = 1'b1;
        t = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
        exp_sum  = t[W-1:0];
        exp_cout = t[W];
    endtask

    // Walk an accepted request from T0 through the done cycle.
    // inj>0 pulses a spurious start (with junk operand) at edge T<inj>.
    task automatic run(input int inj);
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            check("busy_hi", 32'(busy), 32'd1);
            check("done_lo_busy", 32'(done), 32'd0);
            check("sum_held", 32'(sum), 32'(held_sum));
            check("cout_held", 32'(cout), 32'(held_cout));
            if (k + 1 == inj) begin
                start = 1'b1;
                a     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_lo_done", 32'(busy), 32'd0);
        check("done_hi", 32'(done), 32'd1);
        check("sum_result", 32'(sum), 32'(exp_sum));
        check("cout_result", 32'(cout), 32'(exp_cout));
        held_sum  = exp_sum;
        held_cout = exp_cout;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_sum", 32'(sum), 32'(held_sum));
        check("idle_cout", 32'(cout), 32'(held_cout));
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Directed arithmetic cases.
        launch(8'h25, 8'h1A, 1'b0); run(0);
        check("sum_3f", 32'(sum), 32'h3F);
        idle_cycle();
        launch(8'hFF, 8'h01, 1'b0); run(0);
        check("wrap_sum", 32'(sum), 32'h00);
        check("wrap_cout", 32'(cout), 32'd1);
        idle_cycle();
        launch(8'hFF, 8'hFF, 1'b1); run(0);
        check("max_sum", 32'(sum), 32'hFF);
        idle_cycle();

        // Start during BUSY is ignored; done pulses once.
        launch(8'h10, 8'h20, 1'b0); run(3);
        check("ignore_sum", 32'(sum), 32'h30);
        idle_cycle();
        idle_cycle();

        // Abort at T4; reset also overrides a coincident start.
        launch(8'h5A, 8'h33, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h01;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < W + 2; i++) idle_cycle();
        launch(8'h7C, 8'h19, 1'b1); run(0);
        idle_cycle();

        // Back-to-back: restart in the done cycle.
        launch(8'h11, 8'h22, 1'b0); run(0);
        launch(8'h80, 8'h80, 1'b0); run(0);
        check("b2b_sum", 32'(sum), 32'h00);
        check("b2b_cout", 32'(cout), 32'd1);
        idle_cycle();

        // Randomized operations with random spurious starts and gaps.
        for (int n = 0; n < 30; n++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom));
            run(($urandom % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0);
            if ($urandom % 2 == 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one full-adder bit slice (sum = a^b^c, carry = majority) across a WIDTH-bit operation.
- Latches operands on a start pulse and sequences one bit per clock, LSB first, holding carry in a flip-flop.
- Raises a one-cycle done pulse and holds the result until the next operation completes.
- Sits between lab-level stimulus/FSM logic and the adder datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- cin  input  1  carry-in, sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n: all state is cleared on a clk rising edge while rst_n=0.
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flip-flop and bit counter are all 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If start=1 at edge T0, latch a, b and cin into the operand shift registers and carry flip-flop, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each edge T1..TWIDTH:
  - Compute one full-add on the operand LSBs plus the carry flip-flop.
  - Shift the sum bit into the MSB of the internal result shift register.
  - Shift both operands right by one and update the carry flip-flop. Increment the counter.
  - At edge TWIDTH (counter = WIDTH-1 before the increment), copy the completed result into sum, copy the final carry into cout, set done=1, and go to DONE.
- DONE:
  - Lasts exactly one cycle with done=1.
  - start=1 here is accepted like in IDLE (back-to-back operation): relatch operands and go to BUSY.
  - Otherwise go to IDLE.
- busy is 1 exactly in the cycles after edges T0..T(WIDTH-1), i.e. WIDTH cycles, and is 0 in DONE.
- Latency: done is sampled high at edge T(WIDTH+1), measured from the edge T0 that accepted start.
- sum and cout update only on completion. They hold their old value throughout BUSY and until the next completion.
- start in BUSY is ignored, with no queuing. Operand changes after T0 have no effect.
- Arithmetic is modulo 2^WIDTH, and cout is the true carry out of bit WIDTH-1.
- Reset mid-operation: on the edge where rst_n=0, the block aborts to IDLE and all outputs return to their reset values. No done pulse is produced for the aborted operation.
- start coincident with rst_n=0: reset wins, and start is not accepted.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - sub=1: store b inverted and force the initial carry to 1 (cin is ignored); the block computes a-b.
  - sub=1: cout=1 means no borrow (a>=b unsigned).
  - sub=0: normal add.
- When undefined: no sub port, and add only.

Test Plan:
All cases use WIDTH=8.
- a=8'h25, b=8'h1A, cin=0, start pulse at T0 -> busy high 8 cycles; done=1 sampled at T9; sum=8'h3F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start a=8'h10, b=8'h20; pulse start again at T3 with a=8'h00 -> second start ignored; result sum=8'h30; done is a single one-cycle pulse.
- Start an operation, drive rst_n=0 at T4 -> next cycle busy=0, done=0, sum=8'h00, cout=0. No done pulse for that op. A new start completes normally.
- Back-to-back: start in the DONE cycle with a=8'h80, b=8'h80 -> first result held until T9 of the second op; second result sum=8'h00, cout=1.
- SERIAL_ADD_SUB_EN defined, sub=1:
  - a=8'h10, b=8'h20 -> sum=8'hF0, cout=0.
  - a=8'h20, b=8'h10 -> sum=8'h10, cout=1.
